// File: rtl/game_board_scanner_if.sv
// game_board_scanner_if: tile beat stream from the scanner to the renderer.
interface game_board_scanner_if;
  logic       tile_valid;
  logic       tile_ready;
  logic [2:0] tile_code;
  logic [5:0] tile_index;
  logic       tile_last;
  modport master (output tile_valid, tile_code, tile_index, tile_last, input tile_ready);
  modport slave  (input tile_valid, tile_code, tile_index, tile_last, output tile_ready);
endinterface

// File: rtl/game_board_scanner.sv
// game_board_scanner: snapshots the board maps on start and streams 64 tile codes.
module game_board_scanner (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [63:0]                 wall,
  input  logic [63:0]                 way,
  input  logic [63:0]                 box,
  input  logic [63:0]                 destination,
  input  logic [5:0]                  man,
  game_board_scanner_if.master        tile,
  output logic                        busy,
  output logic [7:0]                  frame_count
);
  typedef enum logic {IDLE, SEND} state_e;
  state_e      state_q, state_d;
  logic [5:0]  idx_q, idx_d, man_q, man_d;
  logic [7:0]  fc_q, fc_d;
  logic [63:0] wall_q, wall_d, way_q, way_d, box_q, box_d, dst_q, dst_d;
  logic        fire, on_man, on_goal, on_box;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fc_d    = fc_q;
    man_d   = man_q;
    wall_d  = wall_q;
    way_d   = way_q;
    box_d   = box_q;
    dst_d   = dst_q;
    fire    = (state_q == SEND) && tile.tile_ready;
    if (state_q == IDLE && start) begin
      state_d = SEND;
      idx_d   = 6'd0;
      man_d   = man;
      wall_d  = wall;
      way_d   = way;
      box_d   = box;
      dst_d   = destination;
    end
    if (fire) begin
      idx_d = idx_q + 6'd1;
      if (idx_q == 6'd63) begin
        state_d = IDLE;
        idx_d   = 6'd0;
        fc_d    = fc_q + 8'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 6'd0;
      fc_q    <= 8'd0;
      man_q   <= 6'd0;
      wall_q  <= 64'd0;
      way_q   <= 64'd0;
      box_q   <= 64'd0;
      dst_q   <= 64'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fc_q    <= fc_d;
      man_q   <= man_d;
      wall_q  <= wall_d;
      way_q   <= way_d;
      box_q   <= box_d;
      dst_q   <= dst_d;
    end
  end
  // idx_q is held at 0 whenever IDLE, so index and last need no extra gating
  always_comb begin
    on_man  = idx_q == man_q;
    on_goal = dst_q[idx_q];
    on_box  = box_q[idx_q];
    busy    = state_q == SEND;
    tile.tile_valid = busy;
    tile.tile_index = idx_q;
    tile.tile_last  = busy && (idx_q == 6'd63);
    tile.tile_code  = !busy             ? 3'd0 :
                      on_man && on_goal ? 3'd7 :
                      on_man            ? 3'd6 :
                      on_box && on_goal ? 3'd5 :
                      on_box            ? 3'd4 :
                      wall_q[idx_q]     ? 3'd1 :
                      on_goal           ? 3'd3 :
                      way_q[idx_q]      ? 3'd2 : 3'd0;
  end
  assign frame_count = fc_q;
endmodule

// File: tb/tb_game_board_scanner.sv
// tb_game_board_scanner: randomized frame scans checked against a cell-rule model.
module tb_game_board_scanner;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [63:0] wall, way, box, destination;
  logic [5:0]  man;
  logic        busy;
  logic [7:0]  frame_count;
  logic [7:0]  exp_fc;
  logic [2:0]  exp_code [64];
  int          checks = 0, passed = 0;

  game_board_scanner_if tile();

  game_board_scanner dut (
    .clk(clk), .reset(reset), .start(start), .wall(wall), .way(way), .box(box),
    .destination(destination), .man(man), .tile(tile.master), .busy(busy),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] ref_code(input int i);
    bit m, g;
    m = (i == int'(man));
    g = destination[i];
    if (m && g) return 3'd7;
    if (m) return 3'd6;
    if (box[i] && g) return 3'd5;
    if (box[i]) return 3'd4;
    if (wall[i]) return 3'd1;
    if (g) return 3'd3;
    if (way[i]) return 3'd2;
    return 3'd0;
  endfunction

  task automatic rand_maps();
    wall = {$urandom, $urandom};
    way = {$urandom, $urandom};
    box = {$urandom, $urandom} & {$urandom, $urandom};
    destination = {$urandom, $urandom} & {$urandom, $urandom};
    man = 6'($urandom_range(0, 63));
  endtask

  // rmode: 0 ready always, 1 pattern 1,0,0,1, 2 random
  task automatic run_frame(input int rmode, input bit mutate, input bit poke,
                           output int nb, output int errs);
    int cyc;
    bit pv, r;
    logic [2:0] pc;
    logic [5:0] pi;
    logic pl;
    errs = 0; nb = 0; cyc = 0; pv = 0; pc = 0; pi = 0; pl = 0;
    for (int i = 0; i < 64; i++) exp_code[i] = ref_code(i);
    @(negedge clk);
    start = 1'b1;
    tile.tile_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (cyc < 1000) begin
      if (!tile.tile_valid) break;
      if (nb > 63) begin errs++; break; end
      if (tile.tile_index !== 6'(nb) || tile.tile_code !== exp_code[nb] ||
          tile.tile_last !== (nb == 63) || busy !== 1'b1) errs++;
      if (pv && {tile.tile_code, tile.tile_index, tile.tile_last} !== {pc, pi, pl}) errs++;
      r = rmode == 0 ? 1'b1 : rmode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom);
      if (mutate && nb == 10) begin
        box = {$urandom, $urandom};
        man = 6'($urandom);
      end
      start = poke && (nb == 20 || nb == 63);
      pv = !r;
      pc = tile.tile_code; pi = tile.tile_index; pl = tile.tile_last;
      tile.tile_ready = r;
      if (r) nb++;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    tile.tile_ready = 1'b0;
    if (nb != 64 || tile.tile_valid !== 1'b0) errs++;
    if (nb == 64) exp_fc = exp_fc + 8'd1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; tile.tile_ready = 1'b1;
    rand_maps();
    repeat (2) @(negedge clk);
    exp_fc = 8'd0;
    checks++; if (tile.tile_valid !== 1'b0) $display("FAIL reset_valid: got %0d want 0", tile.tile_valid); else passed++;
    checks++; if (tile.tile_code !== 3'd0) $display("FAIL reset_code: got %0d want 0", tile.tile_code); else passed++;
    checks++; if (tile.tile_index !== 6'd0) $display("FAIL reset_index: got %0d want 0", tile.tile_index); else passed++;
    checks++; if (tile.tile_last !== 1'b0) $display("FAIL reset_last: got %0d want 0", tile.tile_last); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0d want 0", busy); else passed++;
    checks++; if (frame_count !== 8'd0) $display("FAIL reset_fc: got %0d want 0", frame_count); else passed++;
    reset = 1'b0; start = 1'b0; tile.tile_ready = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL idle_no_start: busy got %0d want 0", busy); else passed++;
  endtask

  task automatic test_basic();
    int nb, errs;
    wall = 64'h1; destination = 64'h6; box = 64'h4; way = '1; man = 6'd1;
    run_frame(0, 0, 0, nb, errs);
    checks++; if (exp_code[0] !== 3'd1 || exp_code[1] !== 3'd7 || exp_code[2] !== 3'd5 || exp_code[3] !== 3'd2)
      $display("FAIL basic_model: got %0d%0d%0d%0d want 1752", exp_code[0], exp_code[1], exp_code[2], exp_code[3]); else passed++;
    checks++; if (errs != 0) $display("FAIL basic_beats: errors %0d want 0", errs); else passed++;
    checks++; if (nb != 64) $display("FAIL basic_count: beats %0d want 64", nb); else passed++;
    checks++; if (frame_count !== exp_fc) $display("FAIL basic_fc: got %0d want %0d", frame_count, exp_fc); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL basic_busy: got %0d want 0", busy); else passed++;
    checks++; if ({tile.tile_code, tile.tile_index, tile.tile_last} !== 10'd0)
      $display("FAIL basic_idle_out: got %0h want 0", {tile.tile_code, tile.tile_index, tile.tile_last}); else passed++;
  endtask

  task automatic test_backpressure();
    int nb, errs;
    rand_maps();
    run_frame(1, 0, 0, nb, errs);
    checks++; if (errs != 0) $display("FAIL backpressure_beats: errors %0d want 0", errs); else passed++;
    checks++; if (frame_count !== exp_fc) $display("FAIL backpressure_fc: got %0d want %0d", frame_count, exp_fc); else passed++;
  endtask

  task automatic test_snapshot();
    int nb, errs;
    rand_maps();
    run_frame(0, 1, 0, nb, errs);
    checks++; if (errs != 0) $display("FAIL snapshot_beats: errors %0d want 0", errs); else passed++;
  endtask

  task automatic test_start_busy();
    int nb, errs;
    rand_maps();
    run_frame(0, 0, 1, nb, errs);
    checks++; if (errs != 0) $display("FAIL start_busy_beats: errors %0d want 0", errs); else passed++;
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL start_busy_restart: busy got %0d want 0", busy); else passed++;
    checks++; if (frame_count !== exp_fc) $display("FAIL start_busy_fc: got %0d want %0d", frame_count, exp_fc); else passed++;
  endtask

  task automatic test_reset_mid();
    int nb, errs, cyc;
    rand_maps();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tile.tile_ready = 1'b1;
    cyc = 0;
    while (cyc < 200 && tile.tile_index !== 6'd30) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (tile.tile_index !== 6'd30) $display("FAIL reset_mid_reach: index %0d want 30", tile.tile_index); else passed++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tile.tile_ready = 1'b0;
    exp_fc = 8'd0;
    checks++; if (tile.tile_valid !== 1'b0) $display("FAIL reset_mid_valid: got %0d want 0", tile.tile_valid); else passed++;
    checks++; if (frame_count !== 8'd0) $display("FAIL reset_mid_fc: got %0d want 0", frame_count); else passed++;
    rand_maps();
    run_frame(2, 0, 0, nb, errs);
    checks++; if (errs != 0) $display("FAIL reset_mid_restart: errors %0d want 0", errs); else passed++;
    checks++; if (frame_count !== 8'd1) $display("FAIL reset_mid_fc_after: got %0d want 1", frame_count); else passed++;
  endtask

  task automatic test_random();
    int nb, errs, tot;
    tot = 0;
    for (int f = 0; f < 4; f++) begin
      rand_maps();
      run_frame(2, 0, 0, nb, errs);
      tot += errs;
    end
    checks++; if (tot != 0) $display("FAIL random_frames: errors %0d want 0", tot); else passed++;
    checks++; if (frame_count !== exp_fc) $display("FAIL random_fc: got %0d want %0d", frame_count, exp_fc); else passed++;
  endtask

  task automatic test_wrap();
    int nb, errs, tot;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_fc = 8'd0;
    tot = 0;
    for (int f = 0; f < 255; f++) begin
      rand_maps();
      run_frame(0, 0, 0, nb, errs);
      tot += errs;
    end
    checks++; if (frame_count !== 8'd255) $display("FAIL wrap_255: got %0d want 255", frame_count); else passed++;
    rand_maps();
    run_frame(0, 0, 0, nb, errs);
    tot += errs;
    checks++; if (frame_count !== 8'd0) $display("FAIL wrap_0: got %0d want 0", frame_count); else passed++;
    checks++; if (tot != 0) $display("FAIL wrap_beats: errors %0d want 0", tot); else passed++;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; tile.tile_ready = 1'b0;
    wall = '0; way = '0; box = '0; destination = '0; man = '0; exp_fc = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_snapshot();
    test_start_busy();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/game_board_scanner.md
GAME_BOARD_SCANNER -- requirements
Module: game_board_scanner

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset. Port names: clk, reset.
REQ-002 clk  input  1  Rising-edge clock, shared with the game core.
REQ-003 reset  input  1  Synchronous, active-high reset.
REQ-004 start  input  1  Frame scan request; sampled only in IDLE.
REQ-005 wall  input  64  Wall map; bit i = cell i.
REQ-006 way  input  64  Floor map; bit i = cell i.
REQ-007 box  input  64  Box map; bit i = cell i.
REQ-008 destination  input  64  Goal map; bit i = cell i.
REQ-009 man  input  6  Man cell index, 0..63.
REQ-010 tile_valid  output  1  Tile beat valid.
REQ-011 tile_ready  input  1  Downstream accepts the beat.
REQ-012 tile_code  output  3  Rendered tile type.
REQ-013 tile_index  output  6  Cell index of the current beat.
REQ-014 tile_last  output  1  High on the beat with tile_index = 63.
REQ-015 busy  output  1  High while in SEND.
REQ-016 frame_count  output  8  Number of completed frames; wraps.

Function
REQ-017 The FSM SHALL have two states, IDLE and SEND; it leaves reset in IDLE.
REQ-018 IDLE SHALL move to SEND on the clk edge where start=1, and SHALL snapshot wall, way, box, destination and man into internal registers on that same edge.
REQ-019 All beats of a frame SHALL come from the snapshot only; input changes during SEND SHALL have no effect on the frame.
REQ-020 Latency: if start is sampled at edge N, tile_valid=1 and tile_index=0 SHALL be presented from edge N onward.
REQ-021 Beats SHALL be issued in ascending order, tile_index 0 to 63, with no skipped and no repeated index.
REQ-022 A beat completes on an edge where tile_valid=1 and tile_ready=1; tile_index then increments by 1.
REQ-023 While tile_valid=1 and tile_ready=0, tile_code, tile_index and tile_last SHALL hold stable.
REQ-024 With tile_ready held at 1, the block SHALL sustain one beat per cycle, so a frame takes 64 cycles.
REQ-025 tile_code SHALL be encoded by first match, in this priority order:
- 7 = man on goal (cell = man, goal bit set)
- 6 = man
- 5 = box on goal
- 4 = box
- 1 = wall
- 3 = goal
- 2 = floor (way)
- 0 = otherwise
REQ-026 tile_last SHALL equal tile_valid AND (tile_index == 63).
REQ-027 On completion of the last beat (index 63), the FSM SHALL return to IDLE. On that same edge, tile_valid SHALL go to 0 and frame_count SHALL increment (modulo 256; 255 wraps to 0).
REQ-028 A start asserted while in SEND SHALL be ignored and SHALL not be queued; this includes a start in the same cycle as the last beat.
REQ-029 busy SHALL be high exactly while the state is SEND; tile_valid SHALL equal busy.
REQ-030 In IDLE, tile_code, tile_index and tile_last SHALL be 0.

Reset
REQ-031 When reset=1 at an edge, the block SHALL enter IDLE, and every output SHALL be 0: tile_valid, tile_code, tile_index, tile_last, busy, frame_count.
REQ-032 Reset SHALL take priority over start and over a beat completion in the same cycle.
REQ-033 A reset during SEND SHALL abort the frame without incrementing frame_count.
REQ-034 The next start after reset SHALL begin again at tile_index 0.

Verification
REQ-035 Basic frame:
- Stimulus: wall=64'h1, destination=64'h6, box=64'h4, way=all ones, man=1, tile_ready=1, one start pulse.
- Required beats: idx0 code1; idx1 code7; idx2 code5; idx3..63 code2.
- Required end state: tile_last high only at idx63; frame_count=1; busy low after 64 beats.
REQ-036 Backpressure:
- Stimulus: tile_ready toggles 1,0,0,1 repeatedly.
- Required: outputs held stable during ready=0; exactly 64 beats in order; no duplicate beats.
REQ-037 Snapshot isolation:
- Stimulus: start a frame, then change box and man at beat 10.
- Required: all 64 beats match the maps captured at start.
REQ-038 Start while busy:
- Stimulus: start pulses at beat 20 and on the beat-63 cycle.
- Required: no restart; busy drops after beat 63; frame_count increments by exactly 1.
REQ-039 Reset mid-frame:
- Stimulus: reset at beat 30, then a new start.
- Required: tile_valid=0 and frame_count=0 on the edge after reset; the new frame starts at idx0.
REQ-040 Counter wrap:
- Stimulus: run 256 complete frames.
- Required: frame_count reads 255 and then 0.
